spi_mst: RTL
============

SPI_MST -- requirements
Module: spi_mst

Interface
REQ-001 The module SHALL have parameter NUM_CS, default 4, number of slave selects (1..8).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, TX and RX FIFO entries (power of 2, 2..16).
REQ-003 The module SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port data_i  input  32  register write data.
REQ-006 The module SHALL have port addr_i  input  32  register address; only [3:0] is decoded.
REQ-007 The module SHALL have port we_i  input  1  register write strobe, one access per cycle.
REQ-008 The module SHALL have port re_i  input  1  register read strobe; pops the RX FIFO when addr_i[3:0]=0x4.
REQ-009 The module SHALL have port data_o  output  32  combinational read data for addr_i.
REQ-010 The module SHALL have ports spi_mosi (output, 1), spi_miso (input, 1), spi_clk (output, 1), spi_ss (output, NUM_CS, active-low) and irq (output, 1).

Function
REQ-011 CTRL at 0x0 SHALL be read/write: [0] enable, [1] CPOL, [2] CPHA, [3] ss_assert, [4] lsb_first, [5] irq_en, [15:8] div, [20:16] len (frame = len+1 bits, 1..32), [26:24] cs_sel; other bits read 0.
REQ-012 A DATA write (0x4) SHALL push data_i into the TX FIFO; a DATA read SHALL return the RX FIFO head (0 when empty); re_i at 0x4 SHALL pop it.
REQ-013 STATUS at 0x8 SHALL read: [0] busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] done, [6] tx_ovf, [7] rx_unf, [12:8] tx_count, [20:16] rx_count; writing 1 to [7:5] SHALL clear the matching sticky bit.
REQ-014 Undecoded addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-015 spi_ss[i] SHALL be 0 exactly when ss_assert=1 and cs_sel=i; cs_sel >= NUM_CS SHALL deassert all selects.
REQ-016 The engine FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE SHALL go to LOAD when enable=1, TX not empty and RX not full; otherwise it SHALL stay in IDLE.
REQ-018 LOAD (one cycle) SHALL pop TX and latch CPOL, CPHA, lsb_first, div and len for the frame.
REQ-019 LOAD SHALL set spi_clk=CPOL, and when CPHA=0 it SHALL also drive the first bit on spi_mosi.
REQ-020 In SHIFT, spi_clk SHALL toggle every div+1 clk cycles (period 2*(div+1)), producing 2*(len+1) edges.
REQ-021 With CPHA=0, spi_miso SHALL be sampled on leading edges and the next bit driven on trailing edges; with CPHA=1, the bit SHALL be driven on leading edges and sampled on trailing edges.
REQ-022 Bit order SHALL be MSB-first from bit len, or LSB-first from bit 0 when lsb_first=1.
REQ-023 The received word SHALL be right-aligned in [len:0], with upper bits 0.
REQ-024 After the last edge, SHIFT SHALL wait div+1 cycles, restore spi_clk=CPOL, and go to DONE.
REQ-025 DONE (one cycle) SHALL push the RX word, set done, and return to IDLE.
REQ-026 Back-to-back frames SHALL therefore have a 3-cycle gap plus div+1 cycles.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Clearing enable mid-frame SHALL let the current frame complete, after which the engine SHALL stay in IDLE.
REQ-029 CTRL changes while busy SHALL affect only later frames, except ss_assert and cs_sel, which SHALL take effect immediately.
REQ-030 A push to a full TX FIFO SHALL be dropped and set tx_ovf.
REQ-031 A DATA read with re_i while RX is empty SHALL return 0 and set rx_unf, with no pointer change.
REQ-032 A simultaneous engine pop and bus push on TX SHALL leave tx_count unchanged; the same SHALL hold for a simultaneous engine push and bus pop on RX.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 irq SHALL equal irq_en AND done, registered.
REQ-035 A sticky-clear write in the same cycle as a set event SHALL leave the bit set.

Reset
REQ-036 With rst=0 at a clock edge, CTRL SHALL become 0, FIFOs empty, sticky bits 0 and FSM IDLE.
REQ-037 During and after reset, outputs SHALL be spi_clk=0, spi_mosi=0, spi_ss all 1, irq=0, and data_o=0 while rst=0.
REQ-038 A reset asserted mid-frame SHALL abort the frame, discard any partial RX data, and require no extra recovery cycles.

Verification
REQ-039 Mode 0: div=0, len=7, MSB-first, miso loopback, push 0xA5 -> 8 clocks of period 2, RX=0xA5, done=1, DATA read returns 0x000000A5.
REQ-040 Mode 3, LSB-first, len=15, div=3, push 0x1234, slave returns 0xBEEF -> sclk idle high, period 8 clk, RX=0xBEEF, mosi bit order LSB-first.
REQ-041 Push 5 words at FIFO_DEPTH=4 with enable=0 -> tx_count=4, tx_ovf=1; W1C STATUS[6] -> tx_ovf=0.
REQ-042 Enable with RX full (4 frames unread) -> engine stays in IDLE, busy=0; one DATA pop -> next frame starts.
REQ-043 len=31, data 0xDEADBEEF, loopback -> RX=0xDEADBEEF; rst=0 at edge 20 -> spi_clk=0, FIFOs empty, no RX push.
REQ-044 cs_sel=2, ss_assert=1 -> spi_ss=4'b1011; cs_sel=5 -> spi_ss=4'b1111.

Source files
------------

// File: rtl/spi_mst.sv
// rtl/spi_mst.sv - SPI master with register interface, TX/RX FIFOs and frame engine

module spi_mst_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [31:0]                din,
    input  logic                       pop,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is accepted only when a pop frees the slot in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_mst #(
    parameter int NUM_CS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic              re_i,
    output logic [31:0]       data_o,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] spi_ss,
    output logic              irq
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] CTRL_MASK = 32'h071F_FF3F;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   ctrl_q;
    logic          done_q;
    logic          tx_ovf_q;
    logic          rx_unf_q;

    logic          ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_ss, ctrl_lsb, ctrl_irq_en;
    logic [7:0]    ctrl_div;
    logic [4:0]    ctrl_len;
    logic [2:0]    ctrl_cs;

    logic          cpol_l, cpha_l, lsb_l;
    logic [7:0]    div_l;
    logic [4:0]    len_l;
    logic [31:0]   tx_word;
    logic [31:0]   rx_word;
    logic [7:0]    div_cnt;
    logic [6:0]    edge_cnt;
    logic [6:0]    total_edges;
    logic [4:0]    bit_k;
    logic          div_hit;
    logic          edges_done;
    logic          leading;

    logic [3:0]    reg_addr;
    logic          bus_push, bus_pop, w1c;
    logic          tx_pop, rx_push;
    logic [31:0]   tx_dout, rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          busy;
    logic [31:0]   status;
    logic          unused_addr;

    assign reg_addr    = addr_i[3:0];
    assign unused_addr = ^addr_i[31:4];

    assign ctrl_en     = ctrl_q[0];
    assign ctrl_cpol   = ctrl_q[1];
    assign ctrl_cpha   = ctrl_q[2];
    assign ctrl_ss     = ctrl_q[3];
    assign ctrl_lsb    = ctrl_q[4];
    assign ctrl_irq_en = ctrl_q[5];
    assign ctrl_div    = ctrl_q[15:8];
    assign ctrl_len    = ctrl_q[20:16];
    assign ctrl_cs     = ctrl_q[26:24];

    assign bus_push = we_i && (reg_addr == 4'h4);
    assign bus_pop  = re_i && (reg_addr == 4'h4);
    assign w1c      = we_i && (reg_addr == 4'h8);
    assign tx_pop   = (state == LOAD);
    assign rx_push  = (state == DONE);
    assign busy     = (state != IDLE);

    spi_mst_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus_push),
        .din   (data_i),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_mst_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_word),
        .pop   (bus_pop),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Frame timing helpers: bit k is the pair of edges 2k (leading) and 2k+1 (trailing)
    assign total_edges = {({1'b0, len_l} + 6'd1), 1'b0};
    assign div_hit     = (div_cnt == div_l);
    assign edges_done  = (edge_cnt == total_edges);
    assign bit_k       = edge_cnt[5:1];
    assign leading     = !edge_cnt[0];

    function automatic logic [4:0] bit_idx(input logic [4:0] b);
        return lsb_l ? b : (len_l - b);
    endfunction

    // Register file: CTRL writes, sticky status bits where a set event beats a clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (we_i && (reg_addr == 4'h0)) begin
                ctrl_q <= data_i & CTRL_MASK;
            end
            done_q   <= rx_push || (done_q && !(w1c && data_i[5]));
            tx_ovf_q <= (bus_push && tx_full && !tx_pop) || (tx_ovf_q && !(w1c && data_i[6]));
            rx_unf_q <= (bus_pop && rx_empty) || (rx_unf_q && !(w1c && data_i[7]));
            irq      <= ctrl_irq_en && done_q;
        end
    end

    // Engine state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Engine next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ctrl_en && !tx_empty && !rx_full) state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (div_hit && edges_done) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine datapath: frame latch at LOAD, edge generation and bit shifting in SHIFT
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            div_l    <= '0;
            len_l    <= '0;
            tx_word  <= '0;
            rx_word  <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cpol_l   <= ctrl_cpol;
                    cpha_l   <= ctrl_cpha;
                    lsb_l    <= ctrl_lsb;
                    div_l    <= ctrl_div;
                    len_l    <= ctrl_len;
                    tx_word  <= tx_dout;
                    rx_word  <= '0;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    spi_clk  <= ctrl_cpol;
                    if (!ctrl_cpha) begin
                        spi_mosi <= tx_dout[ctrl_lsb ? 5'd0 : ctrl_len];
                    end
                end
                SHIFT: begin
                    if (div_hit) begin
                        div_cnt <= '0;
                        if (!edges_done) begin
                            spi_clk  <= !spi_clk;
                            edge_cnt <= edge_cnt + 7'd1;
                            if (leading == cpha_l) begin
                                // Drive edge: CPHA=1 drives bit k, CPHA=0 drives bit k+1
                                if (cpha_l) begin
                                    spi_mosi <= tx_word[bit_idx(bit_k)];
                                end else if (bit_k < len_l) begin
                                    spi_mosi <= tx_word[bit_idx(bit_k + 5'd1)];
                                end
                            end else begin
                                rx_word[bit_idx(bit_k)] <= spi_miso;
                            end
                        end else begin
                            spi_clk <= cpol_l;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slave selects follow CTRL immediately, independent of the frame in flight
    always_comb begin
        spi_ss = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (ctrl_ss && (ctrl_cs == 3'(i))) spi_ss[i] = 1'b0;
        end
    end

    assign status = {11'b0, 5'(rx_count), 3'b0, 5'(tx_count),
                     rx_unf_q, tx_ovf_q, done_q, rx_empty, rx_full, tx_empty, tx_full, busy};

    // Combinational read mux, forced to zero while reset is held
    always_comb begin
        data_o = '0;
        if (rst) begin
            case (reg_addr)
                4'h0:    data_o = ctrl_q;
                4'h4:    data_o = rx_empty ? 32'h0 : rx_dout;
                4'h8:    data_o = status;
                default: data_o = '0;
            endcase
        end
    end
endmodule
